// File: rtl/fmul_rr_arbiter.sv
// fmul_rr_arbiter
//
// Shares one FMUL32 multiplier between REQ_NUM requesters. Each cycle at
// most one eligible requester is granted round-robin; its operands, opcode
// and rounding mode are registered onto the fmul_* outputs. A tag pipeline
// of FMUL_LAT+1 stages follows every issued op so its result (and the
// multiplier's val flag) is routed back to the issuing requester's
// one-entry response buffer. A requester stays busy from accept until its
// response is consumed, so it never has more than one op in flight.
//
// Build option: define FMUL_ARB_PRIO0_EN to give requester 0 strict
// priority; requesters 1..REQ_NUM-1 then rotate among themselves and the
// pointer only advances on their grants.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request / grant (one-hot)
//   req_op1/op2/opc/rmode packed request payloads, slot i at [i*W +: W]
//   rsp_valid/rsp_ready   per-requester response buffer full / consume
//   rsp_data/rsp_flag     packed results and captured fmul_val
//   fmul_op1/op2/opc/r_mode  registered drive into FMUL32
//   fmul_result/fmul_val     FMUL32 outputs, valid FMUL_LAT cycles later

module fmul_rr_arbiter #(
   parameter int REQ_NUM  = 4,
   parameter int DATA_W   = 32,
   parameter int OPC_W    = 2,
   parameter int FMUL_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REQ_NUM-1:0]        req_valid,
   output logic [REQ_NUM-1:0]        req_ready,
   input  logic [REQ_NUM*DATA_W-1:0] req_op1,
   input  logic [REQ_NUM*DATA_W-1:0] req_op2,
   input  logic [REQ_NUM*OPC_W-1:0]  req_opc,
   input  logic [REQ_NUM*2-1:0]      req_rmode,
   output logic [REQ_NUM-1:0]        rsp_valid,
   input  logic [REQ_NUM-1:0]        rsp_ready,
   output logic [REQ_NUM*DATA_W-1:0] rsp_data,
   output logic [REQ_NUM-1:0]        rsp_flag,
   output logic [DATA_W-1:0]         fmul_op1,
   output logic [DATA_W-1:0]         fmul_op2,
   output logic [OPC_W-1:0]          fmul_opc,
   output logic [1:0]                fmul_r_mode,
   input  logic [DATA_W-1:0]         fmul_result,
   input  logic                      fmul_val
);

   localparam int ID_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [REQ_NUM-1:0] busy_r;
   logic [ID_W-1:0]    ptr_r;
   logic [FMUL_LAT:0]  tag_vld_r;
   logic [ID_W-1:0]    tag_id_r [0:FMUL_LAT];

   logic [REQ_NUM-1:0] elig_s;
   logic [REQ_NUM-1:0] consume_s;
   logic [ID_W:0]      pick_s;
   logic               grant_vld_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               accept_s;
   logic               cap_vld_s;
   logic [ID_W-1:0]    cap_id_s;
   logic [ID_W-1:0]    ptr_next_s;

   // First eligible index searching upward from ptr with wrap; MSB = found.
   function automatic logic [ID_W:0] rr_pick(input logic [REQ_NUM-1:0] elig,
                                             input logic [ID_W-1:0]    ptr);
      logic            found;
      logic [ID_W-1:0] id;
      logic [ID_W-1:0] idx;
      found = 1'b0;
      id    = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = ID_W'((int'(ptr) + k) % REQ_NUM);
         if (!found && elig[idx]) begin
            found = 1'b1;
            id    = idx;
         end else begin
            found = found;
         end
      end
      return {found, id};
   endfunction

   assign elig_s    = req_valid & ~busy_r;
   assign consume_s = rsp_valid & rsp_ready;
   assign cap_vld_s = tag_vld_r[FMUL_LAT];
   assign cap_id_s  = tag_id_r[FMUL_LAT];

   // Grant selection (optionally with requester 0 in front of the rotation).
   always_comb begin
      pick_s = '0;
`ifdef FMUL_ARB_PRIO0_EN
      if (elig_s[0]) begin
         pick_s = {1'b1, {ID_W{1'b0}}};
      end else begin
         pick_s = rr_pick(elig_s, ptr_r);
      end
`else
      pick_s = rr_pick(elig_s, ptr_r);
`endif
   end

   assign grant_vld_s = pick_s[ID_W];
   assign grant_id_s  = pick_s[ID_W-1:0];
   assign accept_s    = grant_vld_s & ~rst;

   // One-hot grant, suppressed while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (accept_s) begin
         req_ready = {{(REQ_NUM-1){1'b0}}, 1'b1} << grant_id_s;
      end else begin
         req_ready = '0;
      end
   end

   // Pointer successor; in priority mode a grant to requester 0 keeps it.
   always_comb begin
      ptr_next_s = ptr_r;
      if (accept_s) begin
`ifdef FMUL_ARB_PRIO0_EN
         if (grant_id_s != {ID_W{1'b0}}) begin
            ptr_next_s = ID_W'((int'(grant_id_s) + 1) % REQ_NUM);
         end else begin
            ptr_next_s = ptr_r;
         end
`else
         ptr_next_s = ID_W'((int'(grant_id_s) + 1) % REQ_NUM);
`endif
      end else begin
         ptr_next_s = ptr_r;
      end
   end

   // Issue registers, tag pipeline, busy bits and response buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r      <= '0;
         ptr_r       <= '0;
         tag_vld_r   <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_flag    <= '0;
         fmul_op1    <= '0;
         fmul_op2    <= '0;
         fmul_opc    <= '0;
         fmul_r_mode <= 2'b00;
         for (int k = 0; k <= FMUL_LAT; k++) begin
            tag_id_r[k] <= '0;
         end
      end else begin
         ptr_r <= ptr_next_s;
         if (accept_s) begin
            fmul_op1    <= req_op1[grant_id_s*DATA_W +: DATA_W];
            fmul_op2    <= req_op2[grant_id_s*DATA_W +: DATA_W];
            fmul_opc    <= req_opc[grant_id_s*OPC_W +: OPC_W];
            fmul_r_mode <= req_rmode[grant_id_s*2 +: 2];
         end else begin
            fmul_op1 <= fmul_op1;
         end
         tag_vld_r[0] <= accept_s;
         tag_id_r[0]  <= grant_id_s;
         for (int k = 1; k <= FMUL_LAT; k++) begin
            tag_vld_r[k] <= tag_vld_r[k-1];
            tag_id_r[k]  <= tag_id_r[k-1];
         end
         for (int i = 0; i < REQ_NUM; i++) begin
            // Busy guarantees capture and consume never hit the same slot.
            if (consume_s[i]) begin
               rsp_valid[i] <= 1'b0;
               busy_r[i]    <= 1'b0;
            end else begin
               rsp_valid[i] <= rsp_valid[i];
            end
            if (cap_vld_s && (cap_id_s == ID_W'(i))) begin
               rsp_valid[i]                 <= 1'b1;
               rsp_data[i*DATA_W +: DATA_W] <= fmul_result;
               rsp_flag[i]                  <= fmul_val;
            end else begin
               rsp_flag[i] <= rsp_flag[i];
            end
            if (accept_s && (grant_id_s == ID_W'(i))) begin
               busy_r[i] <= 1'b1;
            end else begin
               busy_r[i] <= busy_r[i] & ~consume_s[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_fmul_rr_arbiter.sv
// Bench for fmul_rr_arbiter with a 2-stage FMUL32 behavioural stand-in.
module tb_fmul_rr_arbiter;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_flag;
   logic [N*32-1:0] req_op1, req_op2, rsp_data;
   logic [N*2-1:0]  req_opc, req_rmode;
   logic [31:0]   fmul_op1, fmul_op2, fmul_result;
   logic [1:0]    fmul_opc, fmul_r_mode;
   logic          fmul_val;

   always #5 clk = ~clk;

   fmul_rr_arbiter #(.REQ_NUM(N), .DATA_W(32), .OPC_W(2), .FMUL_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_opc(req_opc), .req_rmode(req_rmode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
      .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_opc(fmul_opc), .fmul_r_mode(fmul_r_mode),
      .fmul_result(fmul_result), .fmul_val(fmul_val)
   );

   // Reference multiplier: opc 0 is a truncating normal-number FP multiply,
   // other opcodes a mixing function; returns {val, result}.
   function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] opc, input logic [1:0] rm);
      logic [47:0] p;
      logic [9:0]  e;
      logic [31:0] r;
      if (opc == 2'd0) begin
         p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
         e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
         if (p[47]) r = {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
         else       r = {a[31] ^ b[31], e[7:0], p[45:23]};
         return {1'b1, r};
      end else begin
         return {^a, a ^ b ^ {28'd0, rm, opc}};
      end
   endfunction

   // FMUL32 stand-in with two cycles of latency from its registered inputs.
   logic [32:0] st1 = 33'd0, st2 = 33'd0;
   always @(posedge clk) begin
      st1 <= fmul_ref(fmul_op1, fmul_op2, fmul_opc, fmul_r_mode);
      st2 <= st1;
   end
   assign fmul_result = st2[31:0];
   assign fmul_val    = st2[32];

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        flag;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int          id;
      logic [31:0] op1, op2;
      logic [1:0]  opc, rm;
      logic [31:0] exp_data;
      logic        exp_flag;
   } vec_t;
   vec_t vec[5];

   int n_checks = 0, n_pass = 0, cyc = 0;
   logic [N-1:0] rdy_s, prev_rv = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One clock: sample grants before the edge, check new responses after it.
   task automatic tick();
      exp_t e;
      logic [32:0] r;
      @(negedge clk);
      rdy_s = req_ready;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            r = fmul_ref(req_op1[i*32 +: 32], req_op2[i*32 +: 32], req_opc[i*2 +: 2], req_rmode[i*2 +: 2]);
            e.id = i; e.data = r[31:0]; e.flag = r[32]; e.due = cyc + 1 + LAT + 1;
            sb.push_back(e);
         end
      end
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i] && !prev_rv[i]) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL rsp_unexpected: requester %0d raised rsp_valid with nothing in flight", i);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", 64'(i), 64'(e.id));
               chk("rsp_data", rsp_data[i*32 +: 32], e.data);
               chk("rsp_flag", rsp_flag[i], e.flag);
               chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
         end
      end
      prev_rv = rsp_valid;
   endtask

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] opc, input logic [1:0] rm);
      req_op1[id*32 +: 32] = a;
      req_op2[id*32 +: 32] = b;
      req_opc[id*2 +: 2]   = opc;
      req_rmode[id*2 +: 2] = rm;
   endtask

   task automatic wait_grant(input int id);
      int k;
      k = 0;
      do begin tick(); k++; end while (!rdy_s[id] && k < 30);
      if (!rdy_s[id]) chk("grant_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_rsp(input int id);
      int k;
      k = 0;
      while (!rsp_valid[id] && k < 30) begin tick(); k++; end
      if (!rsp_valid[id]) chk("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int k = 0; k < cycles; k++) tick();
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      logic [32:0] r;
      logic [3:0]  pat [5];
      pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000; pat[4] = 4'b0000;

      vec[0] = '{1, 32'h3FC00000, 32'h40000000, 2'd0, 2'd0, 32'h40400000, 1'b1};
      vec[1] = '{3, 32'h40000000, 32'h40000000, 2'd0, 2'd1, 32'h40800000, 1'b1};
      vec[2] = '{0, 32'h12345678, 32'h0F0F0F0F, 2'd1, 2'd2, 32'h0, 1'b0};
      vec[3] = '{2, 32'hC0A00000, 32'h3F400000, 2'd0, 2'd3, 32'h0, 1'b0};
      vec[4] = '{1, 32'hDEADBEEF, 32'h00000001, 2'd3, 2'd1, 32'h0, 1'b0};
      for (int v = 2; v < 5; v++) begin
         r = fmul_ref(vec[v].op1, vec[v].op2, vec[v].opc, vec[v].rm);
         vec[v].exp_data = r[31:0];
         vec[v].exp_flag = r[32];
      end

      req_op1 = '0; req_op2 = '0; req_opc = '0; req_rmode = '0;
      rsp_ready = '0;

      // Reset held three cycles with every requester asking.
      rst = 1'b1;
      req_valid = '1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_req_ready", rdy_s, 4'd0);
         chk("rst_rsp_valid", rsp_valid, 4'd0);
         chk("rst_fmul_ops", {fmul_op1, fmul_op2}, 64'd0);
         chk("rst_fmul_mode", {fmul_opc, fmul_r_mode}, 4'd0);
      end
      req_valid = '0;
      rst = 1'b0;
      sb.delete();

      // Single-op vectors.
      for (int v = 0; v < 5; v++) begin
         set_req(vec[v].id, vec[v].op1, vec[v].op2, vec[v].opc, vec[v].rm);
         req_valid[vec[v].id] = 1'b1;
         wait_grant(vec[v].id);
         req_valid = '0;
         chk("issue_op1", fmul_op1, vec[v].op1);
         chk("issue_opc_rm", {fmul_opc, fmul_r_mode}, {vec[v].opc, vec[v].rm});
         wait_rsp(vec[v].id);
         chk("vec_data", rsp_data[vec[v].id*32 +: 32], vec[v].exp_data);
         chk("vec_flag", rsp_flag[vec[v].id], vec[v].exp_flag);
         chk("vec_others_idle", rsp_valid & ~(4'b0001 << vec[v].id), 4'd0);
         rsp_ready[vec[v].id] = 1'b1;
         tick();
         rsp_ready = '0;
         chk("vec_consumed", rsp_valid[vec[v].id], 1'b0);
      end

      // All four at once: grants 0..3 back to back, then nothing until consumed.
      do_reset(1);
      for (int i = 0; i < N; i++)
         set_req(i, 32'h3F800000 + 32'(i) * 32'h00100000, 32'h40400000 - 32'(i) * 32'h00080000,
                 2'(i), 2'(3 - i));
      req_valid = '1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("all4_grant_order", rdy_s, 4'b0001 << k);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("all4_no_regrant", rdy_s, 4'd0);
      end
      chk("all4_all_full", rsp_valid, 4'b1111);
      req_valid = '0;
      rsp_ready = '1;
      tick();
      rsp_ready = '0;
      chk("all4_drained", rsp_valid, 4'd0);

      // Backpressure on requester 2.
      set_req(2, 32'h40E00000, 32'h3E800000, 2'd0, 2'd0);
      req_valid[2] = 1'b1;
      wait_grant(2);
      wait_rsp(2);
      held = rsp_data[2*32 +: 32];
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("bp_no_grant", rdy_s[2], 1'b0);
         chk("bp_data_stable", rsp_data[2*32 +: 32], held);
      end
      rsp_ready[2] = 1'b1;
      tick();
      chk("bp_no_grant_on_consume", rdy_s[2], 1'b0);
      rsp_ready[2] = 1'b0;
      tick();
      chk("bp_grant_after_consume", rdy_s[2], 1'b1);
      req_valid = '0;
      wait_rsp(2);
      rsp_ready[2] = 1'b1;
      tick();
      rsp_ready = '0;

      // Reset one cycle after accepting requester 0.
      set_req(0, 32'h41200000, 32'h41200000, 2'd0, 2'd0);
      req_valid[0] = 1'b1;
      wait_grant(0);
      req_valid = '0;
      do_reset(1);
      for (int k = 0; k < LAT + 3; k++) begin
         tick();
         chk("midrst_no_rsp", rsp_valid[0], 1'b0);
      end
      req_valid[0] = 1'b1;
      tick();
      chk("midrst_busy_cleared", rdy_s[0], 1'b1);
      req_valid = '0;
      wait_rsp(0);
      rsp_ready[0] = 1'b1;
      tick();
      rsp_ready = '0;

      // Continuous requests with immediate consumption: period of 5 cycles.
      do_reset(1);
      req_valid = '1;
      rsp_ready = '1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("steady_grant_pattern", rdy_s, pat[k % 5]);
      end
      req_valid = '0;
      for (int k = 0; k < 8; k++) tick();
      rsp_ready = '0;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("final_idle", rsp_valid, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fmul_rr_arbiter.md
Name: fmul_rr_arbiter

Overview:
- Shares one FMUL32 floating-point multiplier between REQ_NUM requesters.
- Arbitrates issue slots round-robin and drives the FMUL32 operand, opcode and rounding-mode inputs from registers.
- Tracks in-flight operations with a tag pipeline matched to the FMUL latency, and routes each result and its val flag back to the issuing requester's response buffer.
- Sits between the requester-side units and a single FMUL32 instance.

Parameters:
- REQ_NUM, 4: number of requesters (2..8).
- DATA_W, 32: operand/result width; must match FMUL32 DATA_W.
- OPC_W, 2: opcode width (FMUL32 OPERATION_NUM=4).
- FMUL_LAT, 2: cycles from fmul_* inputs registered until fmul_result/fmul_val are valid (0 = combinational unit).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  REQ_NUM  per-requester operation request.
- req_ready  out  REQ_NUM  grant; transfer on req_valid&req_ready.
- req_op1  in  REQ_NUM*DATA_W  packed first operands; requester i at [i*DATA_W +: DATA_W].
- req_op2  in  REQ_NUM*DATA_W  packed second operands.
- req_opc  in  REQ_NUM*OPC_W  packed opcodes.
- req_rmode  in  REQ_NUM*2  packed rounding modes.
- rsp_valid  out  REQ_NUM  result buffer i full.
- rsp_ready  in  REQ_NUM  requester consumes result.
- rsp_data  out  REQ_NUM*DATA_W  packed results.
- rsp_flag  out  REQ_NUM  captured fmul_val per requester.
- fmul_op1, fmul_op2  out  DATA_W  to FMUL32 op1/op2.
- fmul_opc  out  OPC_W  to FMUL32 opc.
- fmul_r_mode  out  2  to FMUL32 r_mode.
- fmul_result  in  DATA_W  from FMUL32 result.
- fmul_val  in  1  from FMUL32 val.

Behaviour:
- Reset (rst=1 at edge):
  - All fmul_* regs, rsp_valid, rsp_data, rsp_flag and busy bits go to 0.
  - All tag stages are invalidated.
  - The RR pointer is set to 0.
  - Any in-flight result is discarded, including one arriving in the cycle after reset.
- Reset during rst=1: req_ready=0.
- Eligibility: requester i is eligible when req_valid[i] & ~busy[i]. busy[i] is set on accept and cleared when its response is consumed, so each requester has at most one outstanding op.
- Grant:
  - Combinational, at most one bit of req_ready per cycle.
  - Picks the first eligible requester searching from ptr upward, with wrap-around.
  - req_ready[i] never asserts while busy[i]=1.
- On accept of requester g at edge E0:
  - fmul_op1/op2/opc/r_mode are loaded from slot g.
  - tag stage 0 is set to {valid=1, id=g}.
  - busy[g]=1.
  - ptr = (g+1) mod REQ_NUM.
- With no accept: ptr holds, the fmul_* regs hold their previous values, and tag stage 0 gets valid=0.
- Tag pipeline: FMUL_LAT+1 stages, shifting every cycle. It is a full pipeline, so a new op can issue every cycle.
- Capture: at edge E0+FMUL_LAT+1, the last tag stage is valid with id g. At that edge:
  - rsp_data[g] = fmul_result and rsp_flag[g] = fmul_val.
  - rsp_valid[g]=1 from that edge on.
  - Accept-to-rsp_valid latency is FMUL_LAT+1 cycles.
- Response:
  - rsp_valid[g], rsp_data[g] and rsp_flag[g] hold until rsp_valid[g]&rsp_ready[g].
  - At that edge rsp_valid[g]=0 and busy[g]=0.
  - rsp_ready while rsp_valid=0 is ignored.
- Same-cycle consume and new request from the same requester: the request is not granted that cycle (busy is still 1). It is eligible from the next cycle, so at most one request per requester every FMUL_LAT+3 cycles.
- Buffer overwrite is impossible by construction: busy guarantees the buffer for id g is empty at capture.
- fmul_val is not used for routing; only the tag valid bit is.

Optional Feature:
- Macro FMUL_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority; whenever it is eligible it is granted. The other requesters are granted round-robin among themselves, and ptr only advances on grants to requesters 1..REQ_NUM-1.
- Undefined: pure round-robin over all requesters as described above.

Test Plan:
- Reset check: hold rst 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0 and all fmul_* =0 throughout.
- Single op, FMUL_LAT=2: req 1 sends op1=0x3FC00000 (1.5), op2=0x40000000 (2.0), opc=0 at E0 → fmul_op1=0x3FC00000 after E0; rsp_valid[1]=1 and rsp_data[1]=0x40400000 after E0+3; others stay 0.
- All four requesters valid from cycle 0 with distinct operands:
  - Grants go 0,1,2,3 on consecutive cycles.
  - Results return to the matching requesters in the same order, one per cycle.
  - No new grants occur until responses are consumed.
- Backpressure: hold rsp_ready[2]=0 for 10 cycles with req_valid[2]=1 → req_ready[2] stays 0; rsp_data[2] stays stable. On rsp_ready pulse, req_ready[2] may assert the following cycle, not the same cycle.
- Mid-flight reset: accept req 0 at E0, assert rst at E0+1 → rsp_valid[0] stays 0 after FMUL_LAT+1 cycles, and busy[0]=0 after reset.
- With FMUL_ARB_PRIO0_EN: req 0 re-requests continuously while reqs 1..3 stay valid → req 0 is granted every time it is not busy; the others rotate 1,2,3 in the gaps.
